vga_tile_timing: RTL and testbench
==================================

Name: vga_tile_timing

Overview:
- Parametrised VGA raster timing generator with tile-grid coordinate decode.
- Drives pixel counters, sync pulses with configurable polarity, and the active-video flag.
- Decodes tile index and in-tile offset for power-of-two tiles.
- Provides line and frame strobes, a frame counter, and sync/active copies delayed to match an N-stage pixel pipeline.
- Sits between the clock/reset and the tile renderer / cursor logic of the game tops. It replaces the ad-hoc x/y/hsync/vsync logic in those tops.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = negative-going, VGA 640x480)
- CW, 10, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1
- TILE_LOG2, 5, log2 of tile edge in pixels (5 gives 32x32 tiles)
- PIPE_DELAY, 2, clk-enable stages of delay on hsync_d/vsync_d/active_d (0 allowed)
- FRAME_W, 8, width of frame_count

Derived: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  pixel advance enable; when low all state holds
- x  out  CW  current column
- y  out  CW  current line
- active  out  1  1 when x<H_ACTIVE and y<V_ACTIVE
- hsync  out  1  horizontal sync at SYNC_POL level when asserted
- vsync  out  1  vertical sync at SYNC_POL level when asserted
- tile_x  out  CW-TILE_LOG2  x >> TILE_LOG2
- tile_y  out  CW-TILE_LOG2  y >> TILE_LOG2
- sub_x  out  TILE_LOG2  x[TILE_LOG2-1:0]
- sub_y  out  TILE_LOG2  y[TILE_LOG2-1:0]
- line_start  out  1  one-clk pulse on entering x==0
- frame_start  out  1  one-clk pulse on entering (0,0)
- frame_count  out  FRAME_W  completed-frame counter
- hsync_d  out  1  hsync delayed PIPE_DELAY enabled cycles
- vsync_d  out  1  vsync delayed PIPE_DELAY enabled cycles
- active_d  out  1  active delayed PIPE_DELAY enabled cycles

Behaviour:
- Reset (async assert, sync release):
  - x=H_TOTAL-1, y=V_TOTAL-1, active=0, hsync=vsync=~SYNC_POL.
  - line_start=frame_start=0, frame_count=0.
  - All delay stages hold active=0 and sync=~SYNC_POL.
  - The first ena after reset therefore enters (0,0).
- Counting, on each clk with ena=1:
  - If x==H_TOTAL-1: x<=0, and y<=(y==V_TOTAL-1)?0:y+1.
  - Otherwise x<=x+1.
  - With ena=0 the counters, sync, active and delay stages hold.
- Registered decodes, updated in the same edge as x/y so they always describe the current x,y:
  - active = x<H_ACTIVE && y<V_ACTIVE. This is strict <; line V_ACTIVE is blanking.
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL. vsync depends on y only and changes at x==0.
- tile_x/tile_y/sub_x/sub_y are pure slices of x/y. They are also valid during blanking; consumers gate them with active.
- line_start:
  - High for exactly one clk, the clk after an enabled edge that set x to 0.
  - Low on every other clk, including held cycles when ena=0.
- frame_start / frame_count:
  - frame_start follows the same rule as line_start, for entry into x==0 && y==0.
  - frame_count increments in the same edge that sets frame_start. It wraps modulo 2^FRAME_W.
  - The entry into (0,0) just after reset counts: frame_count=1 after the first ena.
- Delay line:
  - PIPE_DELAY-deep shift register of {hsync,active,vsync}, shifting only when ena=1.
  - The *_d outputs equal the value the undelayed signal had PIPE_DELAY enabled cycles earlier.
  - PIPE_DELAY=0: *_d are combinationally equal to hsync/vsync/active.
- Reset mid-frame: immediate return to the reset state; the next ena starts a fresh frame.

Test Plan:
- Release rst, ena=1 constant, defaults → first clk gives x=0, y=0, active=1, frame_start=1, line_start=1, frame_count=1. frame_start recurs every 420000 clk.
- Run one line → hsync=0 exactly for x=656..751 (96 clk). active=1 for x=0..639 and 0 for x=640..799. line_start period is 800 clk.
- Run one frame → vsync=0 exactly for y=490..491 (1600 clk). active=0 for all x on y=480..524. y wraps 524→0 together with x 799→0.
- ena toggling 1-of-3 cycles → counts advance once per 3 clk. line_start/frame_start are 1 clk wide. hsync_d lags hsync by exactly 2 enabled cycles (6 clk).
- x=37, y=70 → tile_x=1, sub_x=5, tile_y=2, sub_y=6. With TILE_LOG2=4 → tile_x=2, sub_x=5.
- SYNC_POL=1, PIPE_DELAY=0 → hsync high for x=656..751 and hsync_d identical to it. Assert rst at x=300, y=200 → outputs return to reset values asynchronously, and the next ena gives (0,0) with frame_start.
- Run 256 frames with FRAME_W=8 → frame_count wraps 255→0.

Source files
------------

// File: rtl/vga_tile_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_tile_timing
// Description : VGA raster timing with tile-grid decode, line/frame strobes
//               and pipeline-aligned copies of sync/active.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_tile_timing #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   CW         = 10,
    parameter int   TILE_LOG2  = 5,
    parameter int   PIPE_DELAY = 2,
    parameter int   FRAME_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    output logic [CW-1:0]         x,
    output logic [CW-1:0]         y,
    output logic                  active,
    output logic                  hsync,
    output logic                  vsync,
    output logic [CW-TILE_LOG2-1:0] tile_x,
    output logic [CW-TILE_LOG2-1:0] tile_y,
    output logic [TILE_LOG2-1:0]  sub_x,
    output logic [TILE_LOG2-1:0]  sub_y,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [FRAME_W-1:0]    frame_count,
    output logic                  hsync_d,
    output logic                  vsync_d,
    output logic                  active_d
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] c_H_LAST   = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST   = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          c_SYNC_ON  = SYNC_POL;
    localparam logic          c_SYNC_OFF = ~SYNC_POL;
    // Packed as {hsync, active, vsync}; idle value used by reset and delay line
    localparam logic [2:0]    c_SIG_IDLE = {c_SYNC_OFF, 1'b0, c_SYNC_OFF};

    logic [CW-1:0]      r_x;
    logic [CW-1:0]      r_y;
    logic               r_active;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_count;

    logic [CW-1:0]      w_x_next;
    logic [CW-1:0]      w_y_next;
    logic               w_x_wrap;
    logic               w_frame_wrap;
    logic               w_active_next;
    logic               w_hsync_next;
    logic               w_vsync_next;
    logic [2:0]         w_sig;
    logic [2:0]         w_sig_d;

    // Decodes are computed from the next position so the registered flags
    // always describe the x/y registered on the same edge.
    always_comb begin
        w_x_wrap     = (r_x == c_H_LAST);
        w_frame_wrap = w_x_wrap && (r_y == c_V_LAST);
        w_x_next     = w_x_wrap ? '0 : r_x + CW'(1);
        w_y_next     = r_y;
        if (w_x_wrap) begin
            w_y_next = (r_y == c_V_LAST) ? '0 : r_y + CW'(1);
        end
        w_active_next = (w_x_next < c_H_ACT) && (w_y_next < c_V_ACT);
        w_hsync_next  = ((w_x_next >= c_HS_BEG) && (w_x_next < c_HS_END))
                        ? c_SYNC_ON : c_SYNC_OFF;
        w_vsync_next  = ((w_y_next >= c_VS_BEG) && (w_y_next < c_VS_END))
                        ? c_SYNC_ON : c_SYNC_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= c_H_LAST;
            r_y           <= c_V_LAST;
            r_active      <= 1'b0;
            r_hsync       <= c_SYNC_OFF;
            r_vsync       <= c_SYNC_OFF;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            // Strobes are single-cycle even when ena stays low afterwards
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (ena) begin
                r_x           <= w_x_next;
                r_y           <= w_y_next;
                r_active      <= w_active_next;
                r_hsync       <= w_hsync_next;
                r_vsync       <= w_vsync_next;
                r_line_start  <= w_x_wrap;
                r_frame_start <= w_frame_wrap;
                if (w_frame_wrap) begin
                    r_frame_count <= r_frame_count + FRAME_W'(1);
                end
            end
        end
    end

    assign w_sig = {r_hsync, r_active, r_vsync};

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign w_sig_d = w_sig;
        end else begin : g_delay
            logic [2:0] r_pipe [PIPE_DELAY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= c_SIG_IDLE;
                    end
                end else if (ena) begin
                    r_pipe[0] <= w_sig;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_sig_d = r_pipe[PIPE_DELAY-1];
        end
    endgenerate

    assign x           = r_x;
    assign y           = r_y;
    assign active      = r_active;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign tile_x      = r_x[CW-1:TILE_LOG2];
    assign tile_y      = r_y[CW-1:TILE_LOG2];
    assign sub_x       = r_x[TILE_LOG2-1:0];
    assign sub_y       = r_y[TILE_LOG2-1:0];
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;
    assign hsync_d     = w_sig_d[2];
    assign active_d    = w_sig_d[1];
    assign vsync_d     = w_sig_d[0];

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_tile_timing
// Description : Directed self-checking bench for vga_tile_timing (default,
//               positive-sync/no-delay, and reduced-size timing instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_tile_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Default 640x480 instance
    logic [9:0] d_x, d_y;
    logic       d_active, d_hsync, d_vsync, d_line_start, d_frame_start;
    logic [4:0] d_tile_x, d_tile_y, d_sub_x, d_sub_y;
    logic [7:0] d_frame_count;
    logic       d_hsync_d, d_vsync_d, d_active_d;

    // Positive sync, no delay, 16-pixel tiles
    logic [9:0] a_x, a_y;
    logic       a_active, a_hsync, a_vsync, a_line_start, a_frame_start;
    logic [5:0] a_tile_x, a_tile_y;
    logic [3:0] a_sub_x, a_sub_y;
    logic [7:0] a_frame_count;
    logic       a_hsync_d, a_vsync_d, a_active_d;

    // Reduced raster: 16 x 10 totals, 160 clocks per frame
    logic [4:0] s_x, s_y;
    logic       s_active, s_hsync, s_vsync, s_line_start, s_frame_start;
    logic [2:0] s_tile_x, s_tile_y;
    logic [1:0] s_sub_x, s_sub_y;
    logic [7:0] s_frame_count;
    logic       s_hsync_d, s_vsync_d, s_active_d;

    vga_tile_timing u_def (
        .clk(clk), .rst(rst), .ena(ena),
        .x(d_x), .y(d_y), .active(d_active), .hsync(d_hsync), .vsync(d_vsync),
        .tile_x(d_tile_x), .tile_y(d_tile_y), .sub_x(d_sub_x), .sub_y(d_sub_y),
        .line_start(d_line_start), .frame_start(d_frame_start),
        .frame_count(d_frame_count),
        .hsync_d(d_hsync_d), .vsync_d(d_vsync_d), .active_d(d_active_d)
    );

    vga_tile_timing #(.SYNC_POL(1'b1), .PIPE_DELAY(0), .TILE_LOG2(4)) u_alt (
        .clk(clk), .rst(rst), .ena(ena),
        .x(a_x), .y(a_y), .active(a_active), .hsync(a_hsync), .vsync(a_vsync),
        .tile_x(a_tile_x), .tile_y(a_tile_y), .sub_x(a_sub_x), .sub_y(a_sub_y),
        .line_start(a_line_start), .frame_start(a_frame_start),
        .frame_count(a_frame_count),
        .hsync_d(a_hsync_d), .vsync_d(a_vsync_d), .active_d(a_active_d)
    );

    vga_tile_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CW(5), .TILE_LOG2(2), .PIPE_DELAY(2), .FRAME_W(8)
    ) u_small (
        .clk(clk), .rst(rst), .ena(ena),
        .x(s_x), .y(s_y), .active(s_active), .hsync(s_hsync), .vsync(s_vsync),
        .tile_x(s_tile_x), .tile_y(s_tile_y), .sub_x(s_sub_x), .sub_y(s_sub_y),
        .line_start(s_line_start), .frame_start(s_frame_start),
        .frame_count(s_frame_count),
        .hsync_d(s_hsync_d), .vsync_d(s_vsync_d), .active_d(s_active_d)
    );

    // Expected values as a function of the enabled-edge index k (k=0 is the
    // first edge after reset, landing on (0,0)); k<0 means the reset state.
    function automatic bit hs_def(input int k);
        int xx;
        if (k < 0) return 1'b1;
        xx = k % 800;
        return !((xx >= 656) && (xx < 752));
    endfunction

    function automatic bit act_def(input int k);
        if (k < 0) return 1'b0;
        return ((k % 800) < 640) && (((k / 800) % 525) < 480);
    endfunction

    function automatic bit hs_small(input int k);
        int xx;
        if (k < 0) return 1'b1;
        xx = k % 16;
        return !((xx >= 10) && (xx < 13));
    endfunction

    function automatic bit vs_small(input int k);
        int yy;
        if (k < 0) return 1'b1;
        yy = (k / 16) % 10;
        return !((yy >= 7) && (yy < 9));
    endfunction

    function automatic bit act_small(input int k);
        if (k < 0) return 1'b0;
        return ((k % 16) < 8) && (((k / 16) % 10) < 6);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int vs_low_cnt = 0;
    int ls_cnt     = 0;
    int kk;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst_def_x",        32'(d_x), 799);
        chk("rst_def_y",        32'(d_y), 524);
        chk("rst_def_active",   32'(d_active), 0);
        chk("rst_def_hsync",    32'(d_hsync), 1);
        chk("rst_def_vsync",    32'(d_vsync), 1);
        chk("rst_def_ls",       32'(d_line_start), 0);
        chk("rst_def_fs",       32'(d_frame_start), 0);
        chk("rst_def_fc",       32'(d_frame_count), 0);
        chk("rst_def_hsync_d",  32'(d_hsync_d), 1);
        chk("rst_def_vsync_d",  32'(d_vsync_d), 1);
        chk("rst_def_active_d", 32'(d_active_d), 0);
        chk("rst_alt_hsync",    32'(a_hsync), 0);
        chk("rst_alt_vsync",    32'(a_vsync), 0);
        chk("rst_small_x",      32'(s_x), 15);
        chk("rst_small_y",      32'(s_y), 9);

        // ---------------- first enabled edge ----------------
        rst = 1'b0;
        ena = 1'b1;
        step();
        chk("first_x",  32'(d_x), 0);
        chk("first_y",  32'(d_y), 0);
        chk("first_active", 32'(d_active), 1);
        chk("first_fs", 32'(d_frame_start), 1);
        chk("first_ls", 32'(d_line_start), 1);
        chk("first_fc", 32'(d_frame_count), 1);
        chk("first_small_fc", 32'(s_frame_count), 1);
        chk("first_hsync_d", 32'(d_hsync_d), 1);
        if (s_vsync == 1'b0) vs_low_cnt++;

        // ---------------- continuous run ----------------
        for (int k = 1; k <= 56037; k++) begin
            step();
            if (k < 1600) begin
                chk("def_x",        32'(d_x), k % 800);
                chk("def_hsync",    32'(d_hsync), 32'(hs_def(k)));
                chk("def_active",   32'(d_active), 32'(act_def(k)));
                chk("def_ls",       32'(d_line_start), 32'((k % 800) == 0));
                chk("def_fs",       32'(d_frame_start), 0);
                chk("def_hsync_d",  32'(d_hsync_d), 32'(hs_def(k - 2)));
                chk("def_active_d", 32'(d_active_d), 32'(act_def(k - 2)));
                chk("alt_hsync",    32'(a_hsync), 32'(!hs_def(k)));
                chk("alt_hsync_d",  32'(a_hsync_d), 32'(!hs_def(k)));
                chk("alt_active_d", 32'(a_active_d), 32'(act_def(k)));
                if (d_line_start) ls_cnt++;
            end
            if (k <= 41000) begin
                chk("small_x",        32'(s_x), k % 16);
                chk("small_y",        32'(s_y), (k / 16) % 10);
                chk("small_active",   32'(s_active), 32'(act_small(k)));
                chk("small_hsync",    32'(s_hsync), 32'(hs_small(k)));
                chk("small_vsync",    32'(s_vsync), 32'(vs_small(k)));
                chk("small_vsync_d",  32'(s_vsync_d), 32'(vs_small(k - 2)));
                chk("small_active_d", 32'(s_active_d), 32'(act_small(k - 2)));
                chk("small_ls",       32'(s_line_start), 32'((k % 16) == 0));
                chk("small_fs",       32'(s_frame_start), 32'((k % 160) == 0));
                chk("small_fc",       32'(s_frame_count), (k / 160 + 1) % 256);
                if (k < 160 && s_vsync == 1'b0) vs_low_cnt++;
            end
            if (k == 40640) chk("small_fc_255", 32'(s_frame_count), 255);
            if (k == 40800) chk("small_fc_wrap", 32'(s_frame_count), 0);
        end
        chk("def_ls_count_2lines", ls_cnt, 1);
        chk("small_vsync_low_clks", vs_low_cnt, 32);

        // ---------------- tile decode at x=37, y=70 ----------------
        chk("tile_def_x",   32'(d_x), 37);
        chk("tile_def_y",   32'(d_y), 70);
        chk("tile_def_tx",  32'(d_tile_x), 1);
        chk("tile_def_sx",  32'(d_sub_x), 5);
        chk("tile_def_ty",  32'(d_tile_y), 2);
        chk("tile_def_sy",  32'(d_sub_y), 6);
        chk("tile_alt_tx",  32'(a_tile_x), 2);
        chk("tile_alt_sx",  32'(a_sub_x), 5);
        chk("tile_alt_ty",  32'(a_tile_y), 4);
        chk("tile_alt_sy",  32'(a_sub_y), 6);
        chk("def_fc_hold",  32'(d_frame_count), 1);

        // ---------------- ena one cycle in three ----------------
        kk = 56037;
        for (int p = 0; p < 40; p++) begin
            ena = 1'b1;
            step();
            ena = 1'b0;
            kk++;
            chk("tog_def_x",      32'(d_x), kk % 800);
            chk("tog_small_x",    32'(s_x), kk % 16);
            chk("tog_small_hs",   32'(s_hsync), 32'(hs_small(kk)));
            chk("tog_small_hs_d", 32'(s_hsync_d), 32'(hs_small(kk - 2)));
            chk("tog_small_ls",   32'(s_line_start), 32'((kk % 16) == 0));
            for (int h = 0; h < 2; h++) begin
                step();
                chk("hold_def_x",      32'(d_x), kk % 800);
                chk("hold_small_x",    32'(s_x), kk % 16);
                chk("hold_small_hs_d", 32'(s_hsync_d), 32'(hs_small(kk - 2)));
                chk("hold_small_ls",   32'(s_line_start), 0);
                chk("hold_small_fs",   32'(s_frame_start), 0);
            end
        end
        chk("tog_small_fc", 32'(s_frame_count), 95);

        // ---------------- asynchronous mid-frame reset ----------------
        #3;
        rst = 1'b1;
        #1;
        chk("arst_def_x",       32'(d_x), 799);
        chk("arst_def_y",       32'(d_y), 524);
        chk("arst_def_active",  32'(d_active), 0);
        chk("arst_def_hsync",   32'(d_hsync), 1);
        chk("arst_def_fc",      32'(d_frame_count), 0);
        chk("arst_def_hsync_d", 32'(d_hsync_d), 1);
        chk("arst_alt_hsync",   32'(a_hsync), 0);
        chk("arst_small_x",     32'(s_x), 15);
        chk("arst_small_fc",    32'(s_frame_count), 0);
        step();
        rst = 1'b0;
        ena = 1'b1;
        step();
        chk("rest_def_x",  32'(d_x), 0);
        chk("rest_def_y",  32'(d_y), 0);
        chk("rest_def_fs", 32'(d_frame_start), 1);
        chk("rest_def_ls", 32'(d_line_start), 1);
        chk("rest_def_fc", 32'(d_frame_count), 1);
        chk("rest_def_active", 32'(d_active), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
